// File: rtl/bus_op_sequencer.sv
// Micro-op sequencer for the register/DR bus switch and data-memory handshake.
// Accepts one op per valid/ready handshake and plays out its registered control sequence.
module bus_op_sequencer #(
    parameter int TIMEOUT_W = 8,
    parameter int TIMEOUT   = 200
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       op_valid,
    output logic       op_ready,
    input  logic [2:0] op_code,
    input  logic [2:0] op_src,
    input  logic [2:0] op_dst,
    output logic       read,
    output logic       DR_out,
    output logic [2:0] reg_addr,
    output logic       y_we,
    output logic       dr_ld,
    output logic       mem_req,
    output logic       mem_we,
    input  logic       mem_ack,
    output logic       done,
    output logic       err
);

    // state | meaning
    // IDLE  | waiting for an op, op_ready=1
    // RD    | R[src] onto bus, DR loads it
    // WR    | bus (DR) written into R[dst]
    // MEMW  | DR onto bus, memory write request until ack
    // MEMR  | memory read request until ack
    // MEMLD | DR loads memory read data
    // FIN   | done pulse, err on illegal op or timeout
    typedef enum logic [2:0] {
        S_IDLE, S_RD, S_WR, S_MEMW, S_MEMR, S_MEMLD, S_FIN
    } state_t;

    localparam logic [2:0] OP_RD2DR  = 3'b000;
    localparam logic [2:0] OP_DR2RD  = 3'b001;
    localparam logic [2:0] OP_DR2MEM = 3'b010;
    localparam logic [2:0] OP_MEM2DR = 3'b011;
    localparam logic [2:0] OP_MOV    = 3'b100;

    localparam logic [TIMEOUT_W-1:0] CNT_LAST = TIMEOUT_W'(TIMEOUT - 1);

    state_t               state, state_nxt;
    logic [2:0]           code_q, src_q, dst_q;
    logic [2:0]           src_sel, dst_sel;
    logic [TIMEOUT_W-1:0] wait_cnt, cnt_nxt;
    logic                 err_nxt;

    assign op_ready = (state == S_IDLE);
    // On the accept edge the op fields are still on the inputs, not yet latched.
    assign src_sel  = (state == S_IDLE) ? op_src : src_q;
    assign dst_sel  = (state == S_IDLE) ? op_dst : dst_q;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = wait_cnt;
        err_nxt   = 1'b0;
        case (state)
            S_IDLE: begin
                if (op_valid) begin
                    cnt_nxt = '0;
                    case (op_code)
                        OP_RD2DR, OP_MOV: state_nxt = S_RD;
                        OP_DR2RD:         state_nxt = S_WR;
                        OP_DR2MEM:        state_nxt = S_MEMW;
                        OP_MEM2DR:        state_nxt = S_MEMR;
                        default: begin
                            state_nxt = S_FIN;
                            err_nxt   = 1'b1;
                        end
                    endcase
                end
            end
            S_RD:    state_nxt = (code_q == OP_MOV) ? S_WR : S_FIN;
            S_WR:    state_nxt = S_FIN;
            S_MEMW, S_MEMR: begin
                // An ack on the timeout edge still counts as a normal completion.
                if (mem_ack) begin
                    state_nxt = (state == S_MEMW) ? S_FIN : S_MEMLD;
                end else if (wait_cnt == CNT_LAST) begin
                    state_nxt = S_FIN;
                    err_nxt   = 1'b1;
                end else begin
                    cnt_nxt = wait_cnt + 1'b1;
                end
            end
            S_MEMLD: state_nxt = S_FIN;
            S_FIN:   state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            code_q   <= '0;
            src_q    <= '0;
            dst_q    <= '0;
            wait_cnt <= '0;
            read     <= 1'b0;
            DR_out   <= 1'b0;
            reg_addr <= '0;
            y_we     <= 1'b0;
            dr_ld    <= 1'b0;
            mem_req  <= 1'b0;
            mem_we   <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= cnt_nxt;
            if (state == S_IDLE && op_valid) begin
                code_q <= op_code;
                src_q  <= op_src;
                dst_q  <= op_dst;
            end
            read     <= (state_nxt == S_RD);
            DR_out   <= (state_nxt == S_MEMW);
            reg_addr <= (state_nxt == S_RD) ? src_sel :
                        (state_nxt == S_WR) ? dst_sel : 3'd0;
            y_we     <= (state_nxt == S_WR);
            dr_ld    <= (state_nxt == S_RD) || (state_nxt == S_MEMLD);
            mem_req  <= (state_nxt == S_MEMW) || (state_nxt == S_MEMR);
            mem_we   <= (state_nxt == S_MEMW);
            done     <= (state_nxt == S_FIN);
            err      <= err_nxt;
        end
    end

endmodule

// File: tb/tb_bus_op_sequencer.sv
// Bench for bus_op_sequencer: per-op expected output traces built from the op rules,
// compared against the DUT every cycle, plus directed latency/error literals.
module tb_bus_op_sequencer;

    localparam int TMO = 5;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       op_valid = 1'b0;
    logic [2:0] op_code = '0, op_src = '0, op_dst = '0;
    logic       mem_ack = 1'b0;
    logic       op_ready, read, DR_out, y_we, dr_ld, mem_req, mem_we, done, err;
    logic [2:0] reg_addr;

    bus_op_sequencer #(.TIMEOUT_W(4), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst_n(rst_n), .op_valid(op_valid), .op_ready(op_ready),
        .op_code(op_code), .op_src(op_src), .op_dst(op_dst),
        .read(read), .DR_out(DR_out), .reg_addr(reg_addr), .y_we(y_we),
        .dr_ld(dr_ld), .mem_req(mem_req), .mem_we(mem_we), .mem_ack(mem_ack),
        .done(done), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       op_ready;
        logic       read;
        logic       dr_out;
        logic [2:0] reg_addr;
        logic       y_we;
        logic       dr_ld;
        logic       mem_req;
        logic       mem_we;
        logic       done;
        logic       err;
    } outs_t;

    outs_t exp_q[$];
    outs_t tr[$];
    int    win;
    int    checks = 0, errors = 0;
    bit    chk_en = 0;
    int    cyc = 0, acc_cyc = 0, last_lat = -1;
    logic  last_err = 1'b0;

    function automatic outs_t o_idle();
        outs_t o = '0;
        o.op_ready = 1'b1;
        return o;
    endfunction

    function automatic outs_t o_busy();
        outs_t o = '0;
        return o;
    endfunction

    // Expected per-cycle outputs from C1 to the done cycle for one op.
    task automatic build(input logic [2:0] c, input logic [2:0] s, input logic [2:0] dd, input int d);
        outs_t o;
        bit    to;
        int    n;
        tr.delete();
        to  = !(d >= 1 && d <= TMO);
        n   = to ? TMO : d;
        win = 0;
        case (c)
            3'd0, 3'd4: begin
                o = o_busy(); o.read = 1; o.reg_addr = s; o.dr_ld = 1; tr.push_back(o);
                if (c == 3'd4) begin
                    o = o_busy(); o.y_we = 1; o.reg_addr = dd; tr.push_back(o);
                end
                o = o_busy(); o.done = 1; tr.push_back(o);
            end
            3'd1: begin
                o = o_busy(); o.y_we = 1; o.reg_addr = dd; tr.push_back(o);
                o = o_busy(); o.done = 1; tr.push_back(o);
            end
            3'd2, 3'd3: begin
                win = n;
                for (int i = 0; i < n; i++) begin
                    o = o_busy(); o.mem_req = 1;
                    if (c == 3'd2) begin o.mem_we = 1; o.dr_out = 1; end
                    tr.push_back(o);
                end
                if (c == 3'd3 && !to) begin
                    o = o_busy(); o.dr_ld = 1; tr.push_back(o);
                end
                o = o_busy(); o.done = 1; o.err = to; tr.push_back(o);
            end
            default: begin
                o = o_busy(); o.done = 1; o.err = 1; tr.push_back(o);
            end
        endcase
    endtask

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        outs_t e, a;
        if (chk_en) begin
            e = (exp_q.size() != 0) ? exp_q.pop_front() : o_idle();
            a = {op_ready, read, DR_out, reg_addr, y_we, dr_ld, mem_req, mem_we, done, err};
            checks++;
            if (a !== e) begin
                errors++;
                $display("FAIL outputs cycle %0d: got %b expected %b (ready,read,DR_out,addr,y_we,dr_ld,req,we,done,err)",
                         cyc, a, e);
            end
            if (done === 1'b1) begin
                last_lat = cyc - acc_cyc + 1;
                last_err = err;
            end
        end
    end

    // Accepts one op, drives ack on cycle d of the request (d outside 1..TMO means no ack
    // inside the window), scribbles on op_* and spurious acks where they must be ignored.
    task automatic run_op(input logic [2:0] c, input logic [2:0] s, input logic [2:0] dd,
                          input int d, input bit rst_mid = 0);
        int len;
        build(c, s, dd, d);
        len      = tr.size();
        op_valid = 1'b1;
        op_code  = c;
        op_src   = s;
        op_dst   = dd;
        mem_ack  = 1'($urandom_range(0, 1));
        @(posedge clk); #1;
        acc_cyc = cyc;
        foreach (tr[i]) exp_q.push_back(tr[i]);
        for (int k = 1; k <= len; k++) begin
            op_valid = 1'($urandom_range(0, 1));
            op_code  = 3'($urandom);
            op_src   = 3'($urandom);
            op_dst   = 3'($urandom);
            mem_ack  = (k == d) || (k > win && $urandom_range(0, 1) == 1);
            if (rst_mid && k == 2) begin
                rst_n = 1'b0;
                while (exp_q.size() > 1) void'(exp_q.pop_back());
                @(posedge clk); #1;
                rst_n    = 1'b1;
                op_valid = 1'b0;
                mem_ack  = 1'b0;
                return;
            end
            @(posedge clk); #1;
        end
        op_valid = 1'b0;
        mem_ack  = 1'b0;
    endtask

    task automatic idle_cycles(input int n);
        op_valid = 1'b0;
        repeat (n) begin
            mem_ack = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
        end
        mem_ack = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish by 200000 expected finish");
        $fatal(1);
    end

    initial begin
        logic [2:0] c, s, dd;
        int         d;

        rst_n = 1'b0;
        @(posedge clk); #1;
        chk_en = 1;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        check("reset op_ready", int'(op_ready), 1);
        check("reset outputs", int'({read, DR_out, reg_addr, y_we, dr_ld, mem_req, mem_we, done, err}), 0);

        build(3'd0, 3'd2, 3'd0, 0);
        check("model RD2DR length", tr.size(), 2);
        check("model RD2DR C1 reg_addr", int'(tr[0].reg_addr), 2);
        build(3'd2, 3'd0, 3'd0, 4);
        check("model DR2MEM ack4 length", tr.size(), 5);
        build(3'd3, 3'd0, 3'd0, 1);
        check("model MEM2DR ack1 length", tr.size(), 3);
        check("model MEM2DR C2 dr_ld", int'(tr[1].dr_ld), 1);
        build(3'd3, 3'd0, 3'd0, 0);
        check("model MEM2DR timeout length", tr.size(), TMO + 1);

        run_op(3'd0, 3'd2, 3'd0, 0);
        check("RD2DR latency", last_lat, 2);
        check("RD2DR err", int'(last_err), 0);
        run_op(3'd4, 3'd0, 3'd7, 0);
        check("MOV latency", last_lat, 3);
        check("MOV err", int'(last_err), 0);
        run_op(3'd2, 3'd1, 3'd1, 4);
        check("DR2MEM ack4 latency", last_lat, 5);
        run_op(3'd3, 3'd1, 3'd1, 1);
        check("MEM2DR ack1 latency", last_lat, 3);
        run_op(3'd2, 3'd3, 3'd3, 0);
        check("DR2MEM timeout latency", last_lat, 6);
        check("DR2MEM timeout err", int'(last_err), 1);
        run_op(3'd2, 3'd3, 3'd3, 5);
        check("DR2MEM ack on timeout edge latency", last_lat, 6);
        check("DR2MEM ack on timeout edge err", int'(last_err), 0);
        run_op(3'd3, 3'd4, 3'd4, 6);
        check("MEM2DR late ack latency", last_lat, 6);
        check("MEM2DR late ack err", int'(last_err), 1);
        run_op(3'd6, 3'd5, 3'd5, 0);
        check("illegal latency", last_lat, 1);
        check("illegal err", int'(last_err), 1);

        last_lat = -1;
        run_op(3'd2, 3'd1, 3'd1, 0, 1);
        idle_cycles(3);
        check("reset mid-op no done", last_lat, -1);

        repeat (300) begin
            c  = 3'($urandom_range(0, 7));
            s  = 3'($urandom);
            dd = 3'($urandom);
            d  = $urandom_range(0, TMO + 2);
            run_op(c, s, dd, d);
            check("random op latency", last_lat, tr.size());
            idle_cycles($urandom_range(0, 2));
        end

        idle_cycles(2);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
